intr_source_aggregator: RTL and testbench
=========================================

Name: intr_source_aggregator

Overview:
- Interrupt source stage that produces the single INTR line consumed by the testbench interrupt BFM.
- Collects C_SOURCES event inputs and applies per-source edge or level capture, a pending register, a mask and write-1-to-clear acknowledge.
- Drives INTR through a small FSM that guarantees a minimum deassert gap, so an edge-detecting consumer sees one clean rising edge per interrupt episode.

Parameters:
C_SOURCES, 8, number of sources (1..32)
C_EDGE_MASK, 8'hFF, per-source mode: 1 = rising-edge capture, 0 = level capture
C_MASK_INIT, 0, MASK value at reset (1 = enabled)
C_HOLDOFF_CYCLES, 4, INTR inactive cycles after each assertion (1..65535)
C_ACTIVE, 1, INTR polarity: 1 = active high, 0 = active low

Ports:
CLK  in  1  system clock, all logic on rising edge
nRST  in  1  reset, synchronous, active-low
SRC  in  C_SOURCES  interrupt sources, synchronous to CLK
MASK_WE  in  1  load MASK from MASK_WDATA
MASK_WDATA  in  C_SOURCES  new mask value
CLR_EN  in  1  acknowledge strobe
CLR_DATA  in  C_SOURCES  write-1-to-clear bits for PENDING
PENDING  out  C_SOURCES  pending register (unmasked view)
MASK  out  C_SOURCES  current mask
INTR  out  1  aggregated interrupt, polarity per C_ACTIVE
INTR_ID  out  $clog2(C_SOURCES) (min 1)  lowest-index pending & enabled source
INTR_CNT  out  16  count of assertion episodes, saturating

Behaviour:
Reset (nRST low at an edge):
- PENDING=0, MASK=C_MASK_INIT, INTR=inactive (!C_ACTIVE), INTR_ID=0, INTR_CNT=0, FSM=IDLE, holdoff counter=0.
- The source history register src_d loads SRC during reset, so a source held high through reset release produces no edge.
- Reset mid-episode takes effect at that edge.

Capture, evaluated per bit each edge:
- Edge mode: set = SRC & ~src_d.
- Level mode: set = SRC.
- src_d <= SRC every edge.
- Update: PENDING <= (PENDING & ~(CLR_EN ? CLR_DATA : 0)) | set. A set wins over a simultaneous clear.
- Masked sources still capture into PENDING.

Mask:
- MASK <= MASK_WDATA when MASK_WE, visible the next cycle.
- act = |(PENDING & MASK), using registered values.

FSM:
- IDLE: if act, go to ASSERT, INTR becomes active, INTR_CNT += 1 (saturate at 16'hFFFF).
- ASSERT: INTR active. INTR_ID <= lowest set index of PENDING & MASK, updated every cycle. If !act, go to HOLDOFF, INTR becomes inactive, load counter = C_HOLDOFF_CYCLES-1.
- HOLDOFF: INTR inactive. Counter decrements. At 0, go to IDLE. New pending bits still accumulate during HOLDOFF.
- INTR, INTR_ID and INTR_CNT are all registered outputs.

Latency:
- A source edge sampled at edge k sets PENDING after k. INTR is active after k+1.
- A clear at edge k drops act after k. INTR is inactive after k+1.
- Minimum inactive time between episodes is C_HOLDOFF_CYCLES+1 cycles: holdoff plus the IDLE evaluation cycle.

Boundary conditions:
- A level source held high re-sets PENDING every cycle, so a clear has no lasting effect and INTR stays active.
- Clearing masked bits does not affect INTR.
- Unmasking an already-pending bit in IDLE asserts INTR 2 cycles after MASK_WE.
- Masking all enabled pending bits in ASSERT ends the episode exactly like a clear.
- INTR_ID holds its last value outside ASSERT.
- INTR_CNT never wraps.

Test Plan:
1. Reset with SRC=8'h01 held high (edge mode), then release: PENDING stays 0, INTR stays 0, INTR_CNT=0.
2. MASK=8'hFF, pulse SRC[3] for 1 cycle at edge k: PENDING=8'h08 after k, INTR=1 and INTR_ID=3 after k+1, INTR_CNT=1. Then CLR_EN with CLR_DATA=8'h08: INTR=0 one cycle after PENDING clears, and stays 0 for ≥5 cycles (holdoff 4).
3. SRC[2] and SRC[5] rise together: INTR_ID=2. Clear bit 2: INTR_ID=5 and INTR stays 1. Clear bit 5: INTR falls, INTR_CNT=1 (single episode).
4. SRC[1] rise and CLR_DATA=8'h02 on the same edge: PENDING[1]=1, because set wins.
5. Level mode (C_EDGE_MASK=8'h00), SRC[0] held high, repeated clears: INTR stays 1. Drop SRC[0] then clear: INTR falls.
6. MASK=0, SRC[4] pulse: PENDING=8'h10, INTR=0. Write MASK=8'h10: INTR=1 two cycles after MASK_WE, INTR_ID=4.

Source files
------------

// File: rtl/intr_source_aggregator.sv
// Interrupt source aggregator: per-source edge/level capture into a pending
// register, mask, write-1-to-clear acknowledge, and an INTR output FSM that
// enforces a minimum deassert gap between interrupt episodes.
module intr_source_aggregator #(
    parameter int unsigned C_SOURCES        = 8,
    parameter logic [31:0] C_EDGE_MASK      = 32'h0000_00FF,
    parameter logic [31:0] C_MASK_INIT      = 32'h0000_0000,
    parameter int unsigned C_HOLDOFF_CYCLES = 4,
    parameter bit          C_ACTIVE         = 1'b1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [C_SOURCES-1:0] SRC,
    input  logic                 MASK_WE,
    input  logic [C_SOURCES-1:0] MASK_WDATA,
    input  logic                 CLR_EN,
    input  logic [C_SOURCES-1:0] CLR_DATA,
    output logic [C_SOURCES-1:0] PENDING,
    output logic [C_SOURCES-1:0] MASK,
    output logic                 INTR,
    output logic [((C_SOURCES > 1) ? $clog2(C_SOURCES) : 1)-1:0] INTR_ID,
    output logic [15:0]          INTR_CNT
);

    localparam int unsigned IdW       = (C_SOURCES > 1) ? $clog2(C_SOURCES) : 1;
    localparam logic        IntrOn    = C_ACTIVE;
    localparam logic        IntrOff   = ~C_ACTIVE;
    localparam logic [15:0] HoldLoad  = 16'(C_HOLDOFF_CYCLES - 1);
    localparam logic [15:0] CntMax    = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StHoldoff
    } state_e;

    logic [C_SOURCES-1:0] edge_sel;
    logic [C_SOURCES-1:0] src_hist_q;
    logic [C_SOURCES-1:0] set_bits;
    logic [C_SOURCES-1:0] clr_bits;
    logic [C_SOURCES-1:0] pending_d;
    logic [C_SOURCES-1:0] pending_q;
    logic [C_SOURCES-1:0] mask_q;
    logic [C_SOURCES-1:0] enabled;
    logic                 act;
    logic [IdW-1:0]       low_id;

    state_e               state_q;
    logic                 intr_q;
    logic [IdW-1:0]       id_q;
    logic [15:0]          cnt_q;
    logic [15:0]          hold_q;

    assign edge_sel = C_EDGE_MASK[C_SOURCES-1:0];

    // Capture and acknowledge: a new set always wins over a same-cycle clear.
    always_comb begin
        set_bits  = (SRC & ~src_hist_q & edge_sel) | (SRC & ~edge_sel);
        clr_bits  = CLR_EN ? CLR_DATA : '0;
        pending_d = (pending_q & ~clr_bits) | set_bits;
    end

    // Enabled view of the registered pending/mask state.
    always_comb begin
        enabled = pending_q & mask_q;
        act     = |enabled;
    end

    // Priority encoder: lowest-index enabled pending source.
    always_comb begin
        low_id = '0;
        for (int i = int'(C_SOURCES) - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                low_id = IdW'(i);
            end
        end
    end

    // Source history loads even in reset so a source held high through
    // reset release does not look like a rising edge.
    always_ff @(posedge CLK) begin
        src_hist_q <= SRC;
    end

    // Pending and mask registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pending_q <= '0;
            mask_q    <= C_MASK_INIT[C_SOURCES-1:0];
        end else begin
            pending_q <= pending_d;
            if (MASK_WE) begin
                mask_q <= MASK_WDATA;
            end
        end
    end

    // INTR episode FSM with registered INTR, INTR_ID and INTR_CNT.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= StIdle;
            intr_q  <= IntrOff;
            id_q    <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (act) begin
                        state_q <= StAssert;
                        intr_q  <= IntrOn;
                        // ID valid in the same cycle INTR rises.
                        id_q    <= low_id;
                        if (cnt_q != CntMax) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                StAssert: begin
                    if (act) begin
                        id_q <= low_id;
                    end else begin
                        state_q <= StHoldoff;
                        intr_q  <= IntrOff;
                        hold_q  <= HoldLoad;
                    end
                end
                StHoldoff: begin
                    if (hold_q == 16'd0) begin
                        state_q <= StIdle;
                    end else begin
                        hold_q <= hold_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    intr_q  <= IntrOff;
                end
            endcase
        end
    end

    assign PENDING  = pending_q;
    assign MASK     = mask_q;
    assign INTR     = intr_q;
    assign INTR_ID  = id_q;
    assign INTR_CNT = cnt_q;

endmodule

// File: tb/tb_intr_source_aggregator.sv
// Bench for intr_source_aggregator: an edge-mode instance with an episode
// scoreboard (expected ID/count pushed before stimulus, popped on each INTR
// rising edge) and a level-mode instance checked inline.
module tb_intr_source_aggregator;

    typedef struct {
        logic [2:0]  id;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        nrst;

    // Edge-mode instance
    logic [7:0]  src;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        clr_en;
    logic [7:0]  clr_data;
    logic [7:0]  pending;
    logic [7:0]  mask;
    logic        intr;
    logic [2:0]  intr_id;
    logic [15:0] intr_cnt;

    // Level-mode instance
    logic [7:0]  src_l;
    logic        mask_we_l;
    logic [7:0]  mask_wdata_l;
    logic        clr_en_l;
    logic [7:0]  clr_data_l;
    logic [7:0]  pending_l;
    logic [7:0]  mask_l;
    logic        intr_l;
    logic [2:0]  intr_id_l;
    logic [15:0] intr_cnt_l;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t e;
    logic intr_prev;

    intr_source_aggregator #(
        .C_SOURCES       (8),
        .C_EDGE_MASK     (32'h0000_00FF),
        .C_MASK_INIT     (32'h0),
        .C_HOLDOFF_CYCLES(4),
        .C_ACTIVE        (1'b1)
    ) u_edge (
        .CLK       (clk),
        .nRST      (nrst),
        .SRC       (src),
        .MASK_WE   (mask_we),
        .MASK_WDATA(mask_wdata),
        .CLR_EN    (clr_en),
        .CLR_DATA  (clr_data),
        .PENDING   (pending),
        .MASK      (mask),
        .INTR      (intr),
        .INTR_ID   (intr_id),
        .INTR_CNT  (intr_cnt)
    );

    intr_source_aggregator #(
        .C_SOURCES       (8),
        .C_EDGE_MASK     (32'h0),
        .C_MASK_INIT     (32'h0),
        .C_HOLDOFF_CYCLES(4),
        .C_ACTIVE        (1'b1)
    ) u_level (
        .CLK       (clk),
        .nRST      (nrst),
        .SRC       (src_l),
        .MASK_WE   (mask_we_l),
        .MASK_WDATA(mask_wdata_l),
        .CLR_EN    (clr_en_l),
        .CLR_DATA  (clr_data_l),
        .PENDING   (pending_l),
        .MASK      (mask_l),
        .INTR      (intr_l),
        .INTR_ID   (intr_id_l),
        .INTR_CNT  (intr_cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every INTR rising edge must match the next expected episode.
    always @(negedge clk) begin
        if (nrst && intr && !intr_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL episode_unexpected got id=%0d cnt=%0d, none expected",
                         intr_id, intr_cnt);
            end else begin
                e = exp_q.pop_front();
                if (intr_id !== e.id || intr_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL episode got id=%0d cnt=%0d exp id=%0d cnt=%0d",
                             intr_id, intr_cnt, e.id, e.cnt);
                end
            end
        end
        intr_prev <= intr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        src = 8'h01;
        nrst = 1'b0;
        idle_wait(3);
        nrst = 1'b1;
        tick();
        checks++;
        if (pending !== 8'h00 || intr !== 1'b0 || intr_cnt !== 16'd0 || mask !== 8'h00) begin
            errors++;
            $display("FAIL reset got pend=%h intr=%b cnt=%0d mask=%h exp 00 0 0 00",
                     pending, intr, intr_cnt, mask);
        end
        tick();
        tick();
        checks++;
        if (pending !== 8'h00 || intr !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_src got pend=%h intr=%b exp 00 0", pending, intr);
        end
        src = 8'h00;
        tick();
    endtask

    task automatic test_edge_and_holdoff();
        mask_we = 1'b1;
        mask_wdata = 8'hFF;
        tick();
        mask_we = 1'b0;
        checks++;
        if (mask !== 8'hFF) begin
            errors++;
            $display("FAIL mask_write got %h exp ff", mask);
        end
        exp_q.push_back('{id: 3'd3, cnt: 16'd1});
        src = 8'h08;
        tick();
        src = 8'h00;
        checks++;
        if (pending !== 8'h08 || intr !== 1'b0) begin
            errors++;
            $display("FAIL edge_capture got pend=%h intr=%b exp 08 0", pending, intr);
        end
        tick();
        checks++;
        if (intr !== 1'b1 || intr_id !== 3'd3 || intr_cnt !== 16'd1) begin
            errors++;
            $display("FAIL edge_assert got intr=%b id=%0d cnt=%0d exp 1 3 1",
                     intr, intr_id, intr_cnt);
        end
        // Clear, then a new source arrives right away: it must wait out holdoff.
        exp_q.push_back('{id: 3'd0, cnt: 16'd2});
        clr_en = 1'b1;
        clr_data = 8'h08;
        tick();
        clr_en = 1'b0;
        src = 8'h01;
        checks++;
        if (pending !== 8'h00 || intr !== 1'b1) begin
            errors++;
            $display("FAIL clear_pending got pend=%h intr=%b exp 00 1", pending, intr);
        end
        tick();
        src = 8'h00;
        checks++;
        if (pending !== 8'h01 || intr !== 1'b0) begin
            errors++;
            $display("FAIL clear_intr got pend=%h intr=%b exp 01 0", pending, intr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (intr !== 1'b0) begin
                errors++;
                $display("FAIL holdoff_gap cycle %0d got intr=%b exp 0", i, intr);
            end
        end
        tick();
        checks++;
        if (intr !== 1'b1 || intr_id !== 3'd0 || intr_cnt !== 16'd2) begin
            errors++;
            $display("FAIL holdoff_reassert got intr=%b id=%0d cnt=%0d exp 1 0 2",
                     intr, intr_id, intr_cnt);
        end
        clr_en = 1'b1;
        clr_data = 8'h01;
        tick();
        clr_en = 1'b0;
        idle_wait(7);
    endtask

    task automatic test_priority();
        exp_q.push_back('{id: 3'd2, cnt: 16'd3});
        src = 8'h24;
        tick();
        src = 8'h00;
        tick();
        checks++;
        if (intr !== 1'b1 || intr_id !== 3'd2) begin
            errors++;
            $display("FAIL prio_first got intr=%b id=%0d exp 1 2", intr, intr_id);
        end
        clr_en = 1'b1;
        clr_data = 8'h04;
        tick();
        clr_en = 1'b0;
        tick();
        checks++;
        if (intr !== 1'b1 || intr_id !== 3'd5) begin
            errors++;
            $display("FAIL prio_next got intr=%b id=%0d exp 1 5", intr, intr_id);
        end
        clr_en = 1'b1;
        clr_data = 8'h20;
        tick();
        clr_en = 1'b0;
        tick();
        checks++;
        if (intr !== 1'b0 || intr_cnt !== 16'd3 || intr_id !== 3'd5) begin
            errors++;
            $display("FAIL prio_end got intr=%b cnt=%0d id=%0d exp 0 3 5",
                     intr, intr_cnt, intr_id);
        end
        idle_wait(6);
    endtask

    task automatic test_set_wins();
        exp_q.push_back('{id: 3'd1, cnt: 16'd4});
        src = 8'h02;
        clr_en = 1'b1;
        clr_data = 8'h02;
        tick();
        src = 8'h00;
        clr_en = 1'b0;
        checks++;
        if (pending !== 8'h02) begin
            errors++;
            $display("FAIL set_wins got pend=%h exp 02", pending);
        end
        tick();
        clr_en = 1'b1;
        clr_data = 8'h02;
        tick();
        clr_en = 1'b0;
        tick();
        checks++;
        if (intr !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL set_wins_end got intr=%b pend=%h exp 0 00", intr, pending);
        end
        idle_wait(6);
    endtask

    task automatic test_level();
        mask_we_l = 1'b1;
        mask_wdata_l = 8'h01;
        tick();
        mask_we_l = 1'b0;
        src_l = 8'h01;
        tick();
        tick();
        checks++;
        if (intr_l !== 1'b1 || pending_l !== 8'h01) begin
            errors++;
            $display("FAIL level_assert got intr=%b pend=%h exp 1 01", intr_l, pending_l);
        end
        for (int i = 0; i < 3; i++) begin
            clr_en_l = 1'b1;
            clr_data_l = 8'h01;
            tick();
            checks++;
            if (intr_l !== 1'b1 || pending_l !== 8'h01) begin
                errors++;
                $display("FAIL level_clear_held %0d got intr=%b pend=%h exp 1 01",
                         i, intr_l, pending_l);
            end
        end
        src_l = 8'h00;
        tick();
        clr_en_l = 1'b0;
        tick();
        checks++;
        if (intr_l !== 1'b0 || pending_l !== 8'h00 || intr_cnt_l !== 16'd1) begin
            errors++;
            $display("FAIL level_release got intr=%b pend=%h cnt=%0d exp 0 00 1",
                     intr_l, pending_l, intr_cnt_l);
        end
    endtask

    task automatic test_mask();
        mask_we = 1'b1;
        mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0;
        src = 8'h10;
        tick();
        src = 8'h00;
        tick();
        tick();
        checks++;
        if (pending !== 8'h10 || intr !== 1'b0) begin
            errors++;
            $display("FAIL masked_capture got pend=%h intr=%b exp 10 0", pending, intr);
        end
        exp_q.push_back('{id: 3'd4, cnt: 16'd5});
        mask_we = 1'b1;
        mask_wdata = 8'h10;
        tick();
        mask_we = 1'b0;
        checks++;
        if (intr !== 1'b0) begin
            errors++;
            $display("FAIL unmask_early got intr=%b exp 0", intr);
        end
        tick();
        checks++;
        if (intr !== 1'b1 || intr_id !== 3'd4) begin
            errors++;
            $display("FAIL unmask_assert got intr=%b id=%0d exp 1 4", intr, intr_id);
        end
        // Clearing a masked pending bit leaves the episode alone.
        src = 8'h80;
        tick();
        src = 8'h00;
        clr_en = 1'b1;
        clr_data = 8'h80;
        tick();
        clr_en = 1'b0;
        tick();
        checks++;
        if (intr !== 1'b1 || pending !== 8'h10) begin
            errors++;
            $display("FAIL masked_clear got intr=%b pend=%h exp 1 10", intr, pending);
        end
        mask_we = 1'b1;
        mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0;
        tick();
        checks++;
        if (intr !== 1'b0 || intr_id !== 3'd4 || pending !== 8'h10) begin
            errors++;
            $display("FAIL mask_ends got intr=%b id=%0d pend=%h exp 0 4 10",
                     intr, intr_id, pending);
        end
        idle_wait(6);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        intr_prev = 1'b0;
        nrst = 1'b0;
        src = '0;
        mask_we = 1'b0;
        mask_wdata = '0;
        clr_en = 1'b0;
        clr_data = '0;
        src_l = '0;
        mask_we_l = 1'b0;
        mask_wdata_l = '0;
        clr_en_l = 1'b0;
        clr_data_l = '0;

        test_reset();
        test_edge_and_holdoff();
        test_priority();
        test_set_wins();
        test_level();
        test_mask();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL episodes_missing got %0d outstanding exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
